e203_csr_arbt: RTL and testbench
================================

# e203_csr_arbt

Shares the single-ported CSR file and the EAI coprocessor CSR channel between two requesters: the ALU CSR-instruction path (alu_*) and the debug-module abstract-command path (dbg_*). It performs round-robin arbitration and computes read-modify-write data for CSRRW/CSRRS/CSRRC. It sequences multi-cycle EAI accesses with a timeout and holds one response until the owning requester accepts it. It sits between the EXU/debug front-ends and the CSR register file, so at most one CSR transaction is in flight.

## Interface
- XLEN, 32, data width
- EAI_TMO, 255, max cycles spent in EAI_REQ+EAI_RSP before error completion; 1..255
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_req_valid / dbg_req_valid  in  1  request valid
- alu_req_ready / dbg_req_ready  out  1  request accepted this cycle
- alu_req_idx / dbg_req_idx  in  12  CSR index
- alu_req_op / dbg_req_op  in  2  01=RW, 10=RS, 11=RC; 00 = read-only probe
- alu_req_rs0 / dbg_req_rs0  in  1  operand source is x0 (suppresses RS/RC write)
- alu_req_rdwen / dbg_req_rdwen  in  1  destination needs old value (gates RW read)
- alu_req_opnd / dbg_req_opnd  in  XLEN  rs1 value or zero-extended zimm
- alu_rsp_valid / dbg_rsp_valid  out  1  response valid
- alu_rsp_ready / dbg_rsp_ready  in  1  response accepted
- alu_rsp_rdata / dbg_rsp_rdata  out  XLEN  old CSR value
- alu_rsp_err / dbg_rsp_err  out  1  illegal access, EAI off, or timeout
- csr_ena, csr_wr_en, csr_rd_en  out  1  CSR file strobes
- csr_idx  out  12  CSR file index
- wbck_csr_dat  out  XLEN  CSR file write data
- read_csr_dat  in  XLEN  CSR file read data, combinational
- csr_access_ilgl  in  1  CSR file illegal flag, combinational
- eai_xs_off  in  1  EAI disabled
- eai_csr_valid  out  1  EAI request valid
- eai_csr_ready  in  1  EAI request ready
- eai_csr_addr  out  12  EAI CSR index
- eai_csr_op  out  2  op, forwarded
- eai_csr_wdata  out  XLEN  operand, forwarded; EAI performs RMW itself
- eai_rsp_valid  in  1  EAI response valid
- eai_rsp_ready  out  1  EAI response ready
- eai_rsp_rdata  in  XLEN  EAI old value
- eai_rsp_err  in  1  EAI error

## Operation
- States: IDLE, EAI_REQ, EAI_RSP, RSP. Only IDLE accepts requests. Owner register `own` (0=alu, 1=dbg) and round-robin pointer `rr`; `rr` resets to 0 (ALU preferred).
- Grant in IDLE: only one valid -> it wins. Both valid -> `rr` side wins. On acceptance, `rr` <= ~winner and `own` <= winner. Only the winner's req_ready is 1.
- Selection: EAI range is idx[11:8]==4'hE.
- Internal access, accepted in IDLE:
  - csr_ena=1 in the same cycle.
  - csr_rd_en = RS|RC|(RW&rdwen).
  - csr_wr_en = RW|((RS|RC)&~rs0).
  - wbck_csr_dat: RW opnd; RS opnd|read; RC ~opnd&read; op 00 gives 0 with no write.
  - rdata <= read_csr_dat and err <= csr_access_ilgl are captured. Go to RSP.
- EAI range with eai_xs_off=1: no EAI traffic, err=1, rdata=0. Go to RSP.
- EAI range with EAI on: latch idx/op/opnd, go to EAI_REQ.
  - EAI_REQ: eai_csr_valid=1 until eai_csr_ready, then go to EAI_RSP.
  - EAI_RSP: eai_rsp_ready=1. On eai_rsp_valid, capture rdata/err and go to RSP.
- Timeout: an 8-bit counter clears on entry to EAI_REQ and increments each cycle in EAI_REQ/EAI_RSP. At count==EAI_TMO-1 without completion, go to RSP with err=1, rdata=0. Any later eai_rsp_valid is accepted while IDLE (eai_rsp_ready=1 in IDLE) and discarded.
- RSP: owner's rsp_valid=1 with held rdata/err. On owner's rsp_ready, go to IDLE. The non-owner's rsp_valid is always 0.

## Timing
- Reset: state IDLE, rr=0, own=0, counter=0, rsp data/err=0. All valid/ena/wr/rd outputs are 0.
- Internal access: accept at cycle N, rsp_valid at N+1. The earliest next accept is the cycle after rsp handshake.
- EAI access: accept N, eai_csr_valid from N+1, response in RSP at least N+3.
- eai_csr_valid must not drop before eai_csr_ready; latched fields are stable throughout.
- A req_valid arriving in non-IDLE states sees ready=0 and must hold.
- Asynchronous reset mid-transaction aborts it with no response. Any EAI request in flight is abandoned.

## Structure
- Shared defines header holds: op encodings (RW/RS/RC/NONE), EAI range nibble 4'hE, state encoding, CSR index width 12.
- One natural sub-module: e203_csr_rmw, a combinational RMW/strobe decoder producing wbck data, rd_en and wr_en.

## Test plan
- ALU RS: idx 0x300, opnd 0x8, rs0=0, read 0x1800 -> wr_en=1, wbck 0x1808; rsp next cycle rdata 0x1800, err 0.
- ALU and DBG both valid after reset -> ALU granted first. DBG is granted after ALU rsp; rr flips each grant.
- RC with rs0=1 -> csr_wr_en=0, rd_en=1. RW with rdwen=0 -> rd_en=0, wr_en=1.
- DBG EAI idx 0xE05, eai_csr_ready delayed 3 cycles, rsp rdata 0xABCD -> dbg_rsp rdata 0xABCD; alu_rsp_valid stays 0.
- EAI never responds, EAI_TMO=4 -> err=1 after 4 cycles. A late eai_rsp_valid in IDLE is swallowed.
- eai_xs_off=1 with idx 0xE00 -> no eai_csr_valid; rsp err=1, rdata 0. Reset asserted in EAI_RSP -> all outputs 0 immediately.

Source files
------------

// File: rtl/e203_csr_arbt_pkg.sv
// Shared definitions for the CSR arbiter: op encodings, EAI range nibble,
// FSM state encoding and CSR index width.
package e203_csr_arbt_pkg;

    localparam int CSR_IDX_W = 12;
    localparam logic [3:0] EAI_NIBBLE = 4'hE;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EAI_REQ,
        ST_EAI_RSP,
        ST_RSP
    } arbt_state_e;

    function automatic logic is_eai_idx(input logic [CSR_IDX_W-1:0] idx);
        return idx[CSR_IDX_W-1 -: 4] == EAI_NIBBLE;
    endfunction

endpackage

// File: rtl/e203_csr_arbt_if.sv
// Bundle of the requester, CSR-file and EAI channels around the CSR arbiter.
interface e203_csr_arbt_if #(parameter int XLEN = 32);

    logic            alu_req_valid, alu_req_ready, alu_req_rs0, alu_req_rdwen;
    logic [11:0]     alu_req_idx;
    logic [1:0]      alu_req_op;
    logic [XLEN-1:0] alu_req_opnd;
    logic            alu_rsp_valid, alu_rsp_ready, alu_rsp_err;
    logic [XLEN-1:0] alu_rsp_rdata;

    logic            dbg_req_valid, dbg_req_ready, dbg_req_rs0, dbg_req_rdwen;
    logic [11:0]     dbg_req_idx;
    logic [1:0]      dbg_req_op;
    logic [XLEN-1:0] dbg_req_opnd;
    logic            dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
    logic [XLEN-1:0] dbg_rsp_rdata;

    logic            csr_ena, csr_wr_en, csr_rd_en, csr_access_ilgl;
    logic [11:0]     csr_idx;
    logic [XLEN-1:0] wbck_csr_dat, read_csr_dat;

    logic            eai_xs_off, eai_csr_valid, eai_csr_ready;
    logic [11:0]     eai_csr_addr;
    logic [1:0]      eai_csr_op;
    logic [XLEN-1:0] eai_csr_wdata, eai_rsp_rdata;
    logic            eai_rsp_valid, eai_rsp_ready, eai_rsp_err;

    // The arbiter side.
    modport slave (
        input  alu_req_valid, alu_req_idx, alu_req_op, alu_req_rs0, alu_req_rdwen, alu_req_opnd,
        input  alu_rsp_ready,
        output alu_req_ready, alu_rsp_valid, alu_rsp_rdata, alu_rsp_err,
        input  dbg_req_valid, dbg_req_idx, dbg_req_op, dbg_req_rs0, dbg_req_rdwen, dbg_req_opnd,
        input  dbg_rsp_ready,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err,
        output csr_ena, csr_wr_en, csr_rd_en, csr_idx, wbck_csr_dat,
        input  read_csr_dat, csr_access_ilgl,
        input  eai_xs_off, eai_csr_ready, eai_rsp_valid, eai_rsp_rdata, eai_rsp_err,
        output eai_csr_valid, eai_csr_addr, eai_csr_op, eai_csr_wdata, eai_rsp_ready
    );

    // The requesters plus CSR file and EAI coprocessor, seen as one environment.
    modport master (
        output alu_req_valid, alu_req_idx, alu_req_op, alu_req_rs0, alu_req_rdwen, alu_req_opnd,
        output alu_rsp_ready,
        input  alu_req_ready, alu_rsp_valid, alu_rsp_rdata, alu_rsp_err,
        output dbg_req_valid, dbg_req_idx, dbg_req_op, dbg_req_rs0, dbg_req_rdwen, dbg_req_opnd,
        output dbg_rsp_ready,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err,
        input  csr_ena, csr_wr_en, csr_rd_en, csr_idx, wbck_csr_dat,
        output read_csr_dat, csr_access_ilgl,
        output eai_xs_off, eai_csr_ready, eai_rsp_valid, eai_rsp_rdata, eai_rsp_err,
        input  eai_csr_valid, eai_csr_addr, eai_csr_op, eai_csr_wdata, eai_rsp_ready
    );

endinterface

// File: rtl/e203_csr_rmw.sv
// Combinational read-modify-write decoder: CSR write data and read/write strobes
// for CSRRW/CSRRS/CSRRC and the read-only probe.
module e203_csr_rmw
    import e203_csr_arbt_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op,
    input  logic            rs0,
    input  logic            rdwen,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wbck_dat,
    output logic            rd_en,
    output logic            wr_en
);

    // RW only needs the old value when rd is written; RS/RC with x0 become pure reads.
    always_comb begin
        wbck_dat = '0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (csr_op_e'(op))
            OP_RW: begin
                wbck_dat = opnd;
                rd_en    = rdwen;
                wr_en    = 1'b1;
            end
            OP_RS: begin
                wbck_dat = opnd | rdata;
                rd_en    = 1'b1;
                wr_en    = ~rs0;
            end
            OP_RC: begin
                wbck_dat = ~opnd & rdata;
                rd_en    = 1'b1;
                wr_en    = ~rs0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e203_csr_arbt.sv
// Round-robin arbiter sharing the CSR file and the EAI CSR channel between the
// ALU and debug requesters, with one transaction in flight and a held response.
module e203_csr_arbt
    import e203_csr_arbt_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EAI_TMO = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    e203_csr_arbt_if.slave         bus
);

    arbt_state_e           state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  own_q, own_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic [XLEN-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CSR_IDX_W-1:0]  eai_idx_q, eai_idx_d;
    logic [1:0]            eai_op_q, eai_op_d;
    logic [XLEN-1:0]       eai_opnd_q, eai_opnd_d;

    logic                  win_dbg, accept, sel_eai, tmo_hit, own_rsp_ready;
    logic [CSR_IDX_W-1:0]  sel_idx;
    logic [1:0]            sel_op;
    logic                  sel_rs0, sel_rdwen;
    logic [XLEN-1:0]       sel_opnd, rmw_wbck;
    logic                  rmw_rd_en, rmw_wr_en;

    // A lone requester always wins; with both pending the rr side wins.
    assign win_dbg   = bus.dbg_req_valid & (~bus.alu_req_valid | rr_q);
    assign accept    = (state_q == ST_IDLE) & (bus.alu_req_valid | bus.dbg_req_valid);
    assign sel_idx   = win_dbg ? bus.dbg_req_idx   : bus.alu_req_idx;
    assign sel_op    = win_dbg ? bus.dbg_req_op    : bus.alu_req_op;
    assign sel_rs0   = win_dbg ? bus.dbg_req_rs0   : bus.alu_req_rs0;
    assign sel_rdwen = win_dbg ? bus.dbg_req_rdwen : bus.alu_req_rdwen;
    assign sel_opnd  = win_dbg ? bus.dbg_req_opnd  : bus.alu_req_opnd;
    assign sel_eai   = is_eai_idx(sel_idx);
    assign tmo_hit   = tmo_cnt_q == 8'(EAI_TMO - 1);
    assign own_rsp_ready = own_q ? bus.dbg_rsp_ready : bus.alu_rsp_ready;

    e203_csr_rmw #(.XLEN(XLEN)) u_rmw (
        .op       (sel_op),
        .rs0      (sel_rs0),
        .rdwen    (sel_rdwen),
        .opnd     (sel_opnd),
        .rdata    (bus.read_csr_dat),
        .wbck_dat (rmw_wbck),
        .rd_en    (rmw_rd_en),
        .wr_en    (rmw_wr_en)
    );

    assign bus.alu_req_ready = accept & ~win_dbg;
    assign bus.dbg_req_ready = accept & win_dbg;
    assign bus.csr_ena       = accept & ~sel_eai;
    assign bus.csr_rd_en     = bus.csr_ena & rmw_rd_en;
    assign bus.csr_wr_en     = bus.csr_ena & rmw_wr_en;
    assign bus.csr_idx       = sel_idx;
    assign bus.wbck_csr_dat  = rmw_wbck;

    assign bus.alu_rsp_valid = (state_q == ST_RSP) & ~own_q;
    assign bus.dbg_rsp_valid = (state_q == ST_RSP) & own_q;
    assign bus.alu_rsp_rdata = rsp_rdata_q;
    assign bus.dbg_rsp_rdata = rsp_rdata_q;
    assign bus.alu_rsp_err   = rsp_err_q;
    assign bus.dbg_rsp_err   = rsp_err_q;

    // IDLE also drains any response that shows up after a timeout.
    assign bus.eai_csr_valid = state_q == ST_EAI_REQ;
    assign bus.eai_csr_addr  = eai_idx_q;
    assign bus.eai_csr_op    = eai_op_q;
    assign bus.eai_csr_wdata = eai_opnd_q;
    assign bus.eai_rsp_ready = (state_q == ST_EAI_RSP) | (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        own_d       = own_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        eai_idx_d   = eai_idx_q;
        eai_op_d    = eai_op_q;
        eai_opnd_d  = eai_opnd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rr_d  = ~win_dbg;
                    own_d = win_dbg;
                    if (!sel_eai) begin
                        rsp_rdata_d = bus.read_csr_dat;
                        rsp_err_d   = bus.csr_access_ilgl;
                        state_d     = ST_RSP;
                    end else if (bus.eai_xs_off) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RSP;
                    end else begin
                        eai_idx_d  = sel_idx;
                        eai_op_d   = sel_op;
                        eai_opnd_d = sel_opnd;
                        tmo_cnt_d  = '0;
                        state_d    = ST_EAI_REQ;
                    end
                end
            end
            ST_EAI_REQ: begin
                if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (bus.eai_csr_ready) state_d = ST_EAI_RSP;
                end
            end
            ST_EAI_RSP: begin
                if (bus.eai_rsp_valid) begin
                    rsp_rdata_d = bus.eai_rsp_rdata;
                    rsp_err_d   = bus.eai_rsp_err;
                    state_d     = ST_RSP;
                end else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_RSP: begin
                if (own_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            own_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            eai_idx_q   <= '0;
            eai_op_q    <= '0;
            eai_opnd_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            own_q       <= own_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            eai_idx_q   <= eai_idx_d;
            eai_op_q    <= eai_op_d;
            eai_opnd_q  <= eai_opnd_d;
        end
    end

endmodule

// File: tb/tb_e203_csr_arbt.sv
// Self-checking bench for e203_csr_arbt: expected responses are queued at
// request acceptance and popped when the owner's rsp_valid appears.
module tb_e203_csr_arbt;

    localparam int XLEN = 32;
    localparam int TMO  = 8;

    typedef struct packed {
        logic            own;
        logic [XLEN-1:0] rdata;
        logic            err;
    } rsp_exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   waited;
    rsp_exp_t sb[$];

    e203_csr_arbt_if #(.XLEN(XLEN)) bus ();

    e203_csr_arbt #(.XLEN(XLEN), .EAI_TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit who, input bit v, input logic [11:0] idx,
                                 input logic [1:0] op, input bit rs0, input bit rdwen,
                                 input logic [XLEN-1:0] opnd);
        if (who) begin
            bus.dbg_req_valid = v;  bus.dbg_req_idx = idx;   bus.dbg_req_op = op;
            bus.dbg_req_rs0 = rs0;  bus.dbg_req_rdwen = rdwen; bus.dbg_req_opnd = opnd;
        end else begin
            bus.alu_req_valid = v;  bus.alu_req_idx = idx;   bus.alu_req_op = op;
            bus.alu_req_rs0 = rs0;  bus.alu_req_rdwen = rdwen; bus.alu_req_opnd = opnd;
        end
    endtask

    task automatic pushExp(input bit own, input logic [XLEN-1:0] rdata, input bit err);
        rsp_exp_t e;
        e.own = own; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    // Called just after a posedge; returns just after the posedge that handshakes the response.
    task automatic expectRsp(input int bound, output int n);
        rsp_exp_t e;
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.alu_rsp_valid || bus.dbg_rsp_valid) begin
                seen = 1;
                n = i;
                break;
            end
        end
        if (!seen) begin
            checkOutput("rsp_timeout", 64'd0, 64'd1);
        end else if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            checkOutput("rsp_owner", {63'd0, bus.dbg_rsp_valid}, {63'd0, e.own});
            checkOutput("rsp_both_valid", {63'd0, bus.alu_rsp_valid & bus.dbg_rsp_valid}, 64'd0);
            checkOutput("rsp_rdata", {32'd0, e.own ? bus.dbg_rsp_rdata : bus.alu_rsp_rdata}, {32'd0, e.rdata});
            checkOutput("rsp_err", {63'd0, e.own ? bus.dbg_rsp_err : bus.alu_rsp_err}, {63'd0, e.err});
            checkOutput("req_ready_busy", {62'd0, bus.alu_req_ready, bus.dbg_req_ready}, 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        applyStimulus(1, 0, 12'h0, 2'b00, 0, 0, '0);
        bus.alu_rsp_ready = 1'b1;  bus.dbg_rsp_ready = 1'b1;
        bus.read_csr_dat = '0;     bus.csr_access_ilgl = 1'b0;
        bus.eai_xs_off = 1'b0;     bus.eai_csr_ready = 1'b0;
        bus.eai_rsp_valid = 1'b0;  bus.eai_rsp_rdata = '0;  bus.eai_rsp_err = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_alu_rsp_valid", {63'd0, bus.alu_rsp_valid}, 64'd0);
        checkOutput("rst_dbg_rsp_valid", {63'd0, bus.dbg_rsp_valid}, 64'd0);
        checkOutput("rst_csr_ena", {63'd0, bus.csr_ena}, 64'd0);
        checkOutput("rst_eai_valid", {63'd0, bus.eai_csr_valid}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'd0, bus.alu_rsp_rdata}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Both requesters at once after reset: ALU wins, RS with rs0=0.
        bus.read_csr_dat = 32'h1800;
        applyStimulus(0, 1, 12'h300, 2'b10, 0, 1, 32'h8);
        applyStimulus(1, 1, 12'h341, 2'b01, 0, 1, 32'h55);
        @(negedge clk);
        checkOutput("a_alu_ready", {63'd0, bus.alu_req_ready}, 64'd1);
        checkOutput("a_dbg_ready", {63'd0, bus.dbg_req_ready}, 64'd0);
        checkOutput("a_ena", {63'd0, bus.csr_ena}, 64'd1);
        checkOutput("a_wr_en", {63'd0, bus.csr_wr_en}, 64'd1);
        checkOutput("a_rd_en", {63'd0, bus.csr_rd_en}, 64'd1);
        checkOutput("a_idx", {52'd0, bus.csr_idx}, 64'h300);
        checkOutput("a_wbck", {32'd0, bus.wbck_csr_dat}, 64'h1808);
        pushExp(0, 32'h1800, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        bus.read_csr_dat = 32'h1234;
        expectRsp(4, waited);
        checkOutput("a_latency", 64'(waited), 64'd0);

        // DBG waited through the ALU transaction; RW with rdwen=1.
        @(negedge clk);
        checkOutput("b_dbg_ready", {63'd0, bus.dbg_req_ready}, 64'd1);
        checkOutput("b_wr_en", {63'd0, bus.csr_wr_en}, 64'd1);
        checkOutput("b_wbck", {32'd0, bus.wbck_csr_dat}, 64'h55);
        pushExp(1, 32'h1234, 0);
        @(posedge clk); #1;
        applyStimulus(1, 0, 12'h0, 2'b00, 0, 0, '0);
        expectRsp(4, waited);

        // rr now points at ALU: RC with rs0=1 wins over a DBG RW with rdwen=0.
        bus.read_csr_dat = 32'hFF;
        applyStimulus(0, 1, 12'h304, 2'b11, 1, 1, 32'hF);
        applyStimulus(1, 1, 12'h305, 2'b01, 0, 0, 32'hAA);
        @(negedge clk);
        checkOutput("c_alu_ready", {63'd0, bus.alu_req_ready}, 64'd1);
        checkOutput("c_rc_wr_en", {63'd0, bus.csr_wr_en}, 64'd0);
        checkOutput("c_rc_rd_en", {63'd0, bus.csr_rd_en}, 64'd1);
        pushExp(0, 32'hFF, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        expectRsp(4, waited);

        // ALU returns with a probe while DBG still waits; rr now favours DBG.
        bus.read_csr_dat = 32'h77;
        applyStimulus(0, 1, 12'h306, 2'b00, 0, 1, 32'h1);
        @(negedge clk);
        checkOutput("d_dbg_ready", {63'd0, bus.dbg_req_ready}, 64'd1);
        checkOutput("d_alu_ready", {63'd0, bus.alu_req_ready}, 64'd0);
        checkOutput("d_rw_rd_en", {63'd0, bus.csr_rd_en}, 64'd0);
        checkOutput("d_rw_wr_en", {63'd0, bus.csr_wr_en}, 64'd1);
        checkOutput("d_wbck", {32'd0, bus.wbck_csr_dat}, 64'hAA);
        pushExp(1, 32'h77, 0);
        @(posedge clk); #1;
        applyStimulus(1, 0, 12'h0, 2'b00, 0, 0, '0);
        expectRsp(4, waited);

        // The pending probe: no strobes beyond ena, illegal flag captured.
        bus.csr_access_ilgl = 1'b1;
        @(negedge clk);
        checkOutput("e_alu_ready", {63'd0, bus.alu_req_ready}, 64'd1);
        checkOutput("e_probe_wr", {63'd0, bus.csr_wr_en}, 64'd0);
        checkOutput("e_probe_rd", {63'd0, bus.csr_rd_en}, 64'd0);
        pushExp(0, 32'h77, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        bus.csr_access_ilgl = 1'b0;
        expectRsp(4, waited);

        // DBG EAI access with eai_csr_ready held off for three cycles.
        applyStimulus(1, 1, 12'hE05, 2'b10, 0, 1, 32'h3);
        @(negedge clk);
        checkOutput("f_dbg_ready", {63'd0, bus.dbg_req_ready}, 64'd1);
        checkOutput("f_no_csr_ena", {63'd0, bus.csr_ena}, 64'd0);
        pushExp(1, 32'hABCD, 0);
        @(posedge clk); #1;
        applyStimulus(1, 0, 12'h0, 2'b00, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("f_eai_valid", {63'd0, bus.eai_csr_valid}, 64'd1);
            checkOutput("f_eai_addr", {52'd0, bus.eai_csr_addr}, 64'hE05);
        end
        checkOutput("f_eai_op", {62'd0, bus.eai_csr_op}, 64'd2);
        checkOutput("f_eai_wdata", {32'd0, bus.eai_csr_wdata}, 64'h3);
        @(posedge clk); #1;
        bus.eai_csr_ready = 1'b1;
        @(posedge clk); #1;
        bus.eai_csr_ready = 1'b0;
        @(negedge clk);
        checkOutput("f_eai_valid_drop", {63'd0, bus.eai_csr_valid}, 64'd0);
        checkOutput("f_eai_rsp_ready", {63'd0, bus.eai_rsp_ready}, 64'd1);
        @(posedge clk); #1;
        bus.eai_rsp_valid = 1'b1;
        bus.eai_rsp_rdata = 32'hABCD;
        @(posedge clk); #1;
        bus.eai_rsp_valid = 1'b0;
        bus.eai_rsp_rdata = '0;
        expectRsp(4, waited);

        // EAI never answers: error completion after TMO cycles in the EAI states.
        applyStimulus(0, 1, 12'hE10, 2'b01, 0, 1, 32'h1);
        @(negedge clk);
        checkOutput("g_alu_ready", {63'd0, bus.alu_req_ready}, 64'd1);
        pushExp(0, 32'h0, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        expectRsp(TMO + 4, waited);
        checkOutput("g_tmo_cycles", 64'(waited), 64'(TMO));

        // Late EAI response in IDLE is swallowed without a requester response.
        bus.eai_rsp_valid = 1'b1;
        bus.eai_rsp_rdata = 32'hDEAD;
        @(negedge clk);
        checkOutput("h_idle_rsp_ready", {63'd0, bus.eai_rsp_ready}, 64'd1);
        @(posedge clk); #1;
        bus.eai_rsp_valid = 1'b0;
        @(negedge clk);
        checkOutput("h_no_rsp", {62'd0, bus.alu_rsp_valid, bus.dbg_rsp_valid}, 64'd0);

        // EAI disabled: immediate error response, held until the owner accepts.
        @(posedge clk); #1;
        bus.eai_xs_off = 1'b1;
        bus.alu_rsp_ready = 1'b0;
        applyStimulus(0, 1, 12'hE00, 2'b01, 0, 1, 32'h5);
        @(negedge clk);
        checkOutput("i_alu_ready", {63'd0, bus.alu_req_ready}, 64'd1);
        checkOutput("i_no_csr_ena", {63'd0, bus.csr_ena}, 64'd0);
        pushExp(0, 32'h0, 1);
        @(posedge clk); #1;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        @(negedge clk);
        checkOutput("i_no_eai_valid", {63'd0, bus.eai_csr_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("i_rsp_held", {63'd0, bus.alu_rsp_valid}, 64'd1);
        @(posedge clk); #1;
        bus.alu_rsp_ready = 1'b1;
        bus.eai_xs_off = 1'b0;
        expectRsp(4, waited);

        // Reset while in EAI_RSP aborts the access with no response.
        applyStimulus(1, 1, 12'hE20, 2'b10, 0, 1, 32'h9);
        bus.eai_csr_ready = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 0, 12'h0, 2'b00, 0, 0, '0);
        @(posedge clk); #1;
        bus.eai_csr_ready = 1'b0;
        @(negedge clk);
        checkOutput("j_in_eai_rsp", {62'd0, bus.eai_csr_valid, bus.eai_rsp_ready}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("j_rst_valids", {60'd0, bus.eai_csr_valid, bus.alu_rsp_valid,
                                     bus.dbg_rsp_valid, bus.csr_ena}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("j_no_rsp", {62'd0, bus.alu_rsp_valid, bus.dbg_rsp_valid}, 64'd0);
        checkOutput("j_sb_empty", 64'(sb.size()), 64'd0);

        // rr is back at ALU after reset.
        @(posedge clk); #1;
        bus.read_csr_dat = 32'h42;
        applyStimulus(0, 1, 12'h310, 2'b10, 1, 1, 32'h0);
        applyStimulus(1, 1, 12'h311, 2'b10, 1, 1, 32'h0);
        @(negedge clk);
        checkOutput("k_alu_ready", {63'd0, bus.alu_req_ready}, 64'd1);
        checkOutput("k_dbg_ready", {63'd0, bus.dbg_req_ready}, 64'd0);
        pushExp(0, 32'h42, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 12'h0, 2'b00, 0, 0, '0);
        applyStimulus(1, 0, 12'h0, 2'b00, 0, 0, '0);
        expectRsp(4, waited);
        checkOutput("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
